lc3_mem_access_ctrl: RTL and testbench
======================================

// Module: lc3_mem_access_ctrl
// PURPOSE
//  Sequencer between LC-3 execute/EA-calc and the data-memory stage (MAR register + Dataram).
//  Accepts one memory instruction per START; drives MAR load/select, write enable and store data.
//  Returns the loaded word to the register-file writeback.
//  Covers LD, LDR, LDI, ST, STR, STI, including the MAR<-mem[MAR] hop for indirect ops.
// PARAMETERS
//  ADDR_W      16       address width, equal to the MAR width
//  DATA_W      16       data word width
//  USER_LO     16'h3000 lowest user-accessible address (ACV feature only)
//  USER_HI     16'hFDFF highest user-accessible address (ACV feature only)
// PORTS
//  CLK         in  1       rising-edge clock, shared with data-memory stage
//  RST_N       in  1       asynchronous active-low reset
//  START       in  1       request; sampled only in IDLE
//  OPCODE      in  4       LC-3 IR[15:12]
//  EA          in  ADDR_W  effective address from EA adder
//  SR_DATA     in  DATA_W  store source register value
//  PRIV_USER   in  1       1 = user mode (used only with LC3_MEM_ACV_EN)
//  MEM_DATA    in  DATA_W  memory stage DATA: combinational read of current MAR
//  Y_OUT       out ADDR_W  latched EA; drives memory-stage Y
//  MAR_LE      out 1       MAR load enable
//  MAR_CONTROL out 1       MAR source: 0 = Y_OUT, 1 = MEM_DATA (indirect)
//  WE          out 1       memory write strobe
//  WR_DATA     out DATA_W  latched store data; drives RD_DATA
//  LOAD_DATA   out DATA_W  loaded word, held until the next load completes
//  LOAD_VALID  out 1       1-cycle pulse with DONE for a successful load
//  BUSY        out 1       1 in any state other than IDLE
//  DONE        out 1       1-cycle completion pulse
//  ACV         out 1       access violation flag, valid with DONE
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE. Reset is async from any state.
//   WE, MAR_LE and MAR_CONTROL are decoded from state, so they drop immediately.
//   An aborted store never completes.
//  States: IDLE -> ADDR -> [IND] -> ACCESS -> FIN -> IDLE.
//  IDLE
//   START=1 latches OPCODE, EA->Y_OUT and SR_DATA->WR_DATA, then goes to ADDR.
//   START=0: stay in IDLE.
//  ADDR: MAR_LE=1, MAR_CONTROL=0. Go to IND if LDI/STI, else ACCESS.
//  IND: MAR_LE=1, MAR_CONTROL=1, so MAR <= mem[EA]. Go to ACCESS.
//  ACCESS
//   Load: LOAD_DATA <= MEM_DATA.
//   Store: WE=1 for exactly this cycle.
//   Always go to FIN.
//  FIN: DONE=1; LOAD_VALID=1 if load; then IDLE. BUSY drops on the cycle after FIN.
//  Latency, START edge to DONE: direct ops 3 cycles, indirect ops 4 cycles.
//   Back-to-back throughput is START accepted every 4 / 5 cycles.
//  START while BUSY is ignored; there is no queueing.
//   EA and SR_DATA are don't-care outside the START cycle.
//  Non-memory OPCODE with START: IDLE -> FIN directly. DONE=1, no MAR_LE/WE, LOAD_VALID=0.
//  Addresses wrap modulo 2^ADDR_W; no arithmetic in this block.
//  Outputs are never X after reset. WR_DATA and Y_OUT hold their value between operations.
// CONFIGURATION
//  Macro LC3_MEM_ACV_EN.
//  Defined:
//   In ACCESS, if PRIV_USER=1 and the final address (MAR: EA, or mem[EA] for indirect)
//    is outside [USER_LO, USER_HI], the access is suppressed: WE=0, LOAD_DATA unchanged.
//   FIN then asserts DONE=1, ACV=1, LOAD_VALID=0.
//   The check needs MAR, so a shadow copy of MAR is kept internally.
//  Undefined: ACV is tied 0, PRIV_USER is ignored, USER_LO/USER_HI are unused.
//   Port list is identical in both builds.
// STRUCTURE
//  Package lc3_pkg: opcode constants (OP_LD=4'h2, OP_ST=4'h3, OP_LDR=4'h6, OP_STR=4'h7,
//   OP_LDI=4'hA, OP_STI=4'hB), mem_state_t enum (IDLE, ADDR, IND, ACCESS, FIN),
//   and default USER_LO/USER_HI.
//  Sub-module lc3_mem_acv_check: combinational range compare, instantiated only under the macro.
// TESTING
//  1 LD: mem[16'h3050]=16'hBEEF, START with OP=2, EA=3050.
//    -> MAR_LE at cycle+1, DONE and LOAD_VALID at cycle+3, LOAD_DATA=BEEF, WE never high.
//  2 STI: mem[3100]=4000, SR_DATA=1234.
//    -> WE single pulse at cycle+3 with MAR=4000, then mem[4000]=1234, DONE at cycle+4.
//  3 START pulsed during BUSY, then OP=4'h1 (ADD) in IDLE.
//    -> the busy pulse is ignored; ADD gives DONE next cycle with no MAR_LE/WE.
//  4 RST_N low during the ACCESS cycle of an STR.
//    -> WE falls within the same cycle, mem unchanged, all outputs 0, state IDLE.
//  5 (ACV_EN) PRIV_USER=1, LD EA=2FFF.
//    -> DONE with ACV=1, LOAD_VALID=0, LOAD_DATA unchanged.
//    With PRIV_USER=0 the same LD succeeds.
//  6 Back-to-back LDR, LDR.
//    -> second START accepted on the cycle after DONE; LOAD_DATA updates per op.

Source files
------------

// File: rtl/lc3_mem_access_ctrl_pkg.sv
// LC-3 memory-access sequencer shared definitions: opcodes, FSM states,
// default user-space window and opcode classification helpers.
package lc3_pkg;

    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_STI = 4'hB;

    localparam logic [15:0] USER_LO_DEFAULT = 16'h3000;
    localparam logic [15:0] USER_HI_DEFAULT = 16'hFDFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        IND    = 3'd2,
        ACCESS = 3'd3,
        FIN    = 3'd4
    } mem_state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            OP_LD, OP_ST, OP_LDR, OP_STR, OP_LDI, OP_STI: is_mem_op = 1'b1;
            default:                                      is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_load_op(input logic [3:0] op);
        case (op)
            OP_LD, OP_LDR, OP_LDI: is_load_op = 1'b1;
            default:               is_load_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_ind_op(input logic [3:0] op);
        case (op)
            OP_LDI, OP_STI: is_ind_op = 1'b1;
            default:        is_ind_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lc3_mem_access_ctrl_acv_check.sv
// Combinational user-space window compare used by the access-violation build.
module lc3_mem_acv_check
    import lc3_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] USER_LO = ADDR_W'(USER_LO_DEFAULT),
    parameter logic [ADDR_W-1:0] USER_HI = ADDR_W'(USER_HI_DEFAULT)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    // Inclusive window test on the final (post-indirection) address.
    always_comb begin
        in_range = 1'b0;
        if ((addr >= USER_LO) && (addr <= USER_HI)) begin
            in_range = 1'b1;
        end else begin
            in_range = 1'b0;
        end
    end

endmodule

// File: rtl/lc3_mem_access_ctrl.sv
// LC-3 data-memory access sequencer: IDLE -> ADDR -> [IND] -> ACCESS -> FIN.
// Optional feature: define LC3_MEM_ACV_EN to enable user-mode access-violation
// checking (keeps a shadow copy of MAR); otherwise ACV is tied low.
module lc3_mem_access_ctrl
    import lc3_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter logic [ADDR_W-1:0] USER_LO = ADDR_W'(USER_LO_DEFAULT),
    parameter logic [ADDR_W-1:0] USER_HI = ADDR_W'(USER_HI_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [3:0]        OPCODE,
    input  logic [ADDR_W-1:0] EA,
    input  logic [DATA_W-1:0] SR_DATA,
    input  logic              PRIV_USER,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [ADDR_W-1:0] Y_OUT,
    output logic              MAR_LE,
    output logic              MAR_CONTROL,
    output logic              WE,
    output logic [DATA_W-1:0] WR_DATA,
    output logic [DATA_W-1:0] LOAD_DATA,
    output logic              LOAD_VALID,
    output logic              BUSY,
    output logic              DONE,
    output logic              ACV
);

    mem_state_t        state_r, state_nxt_s;
    logic [3:0]        opcode_r;
    logic [ADDR_W-1:0] y_out_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [DATA_W-1:0] load_data_r;
    logic              acv_r;
    logic              acv_hit_s;

`ifdef LC3_MEM_ACV_EN
    logic [ADDR_W-1:0] mar_shadow_r;
    logic              in_range_s;

    // Mirror the external MAR so the final address can be range-checked.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mar_shadow_r <= {ADDR_W{1'b0}};
        end else if (state_r == ADDR) begin
            mar_shadow_r <= y_out_r;
        end else if (state_r == IND) begin
            mar_shadow_r <= MEM_DATA[ADDR_W-1:0];
        end
    end

    lc3_mem_acv_check #(
        .ADDR_W  (ADDR_W),
        .USER_LO (USER_LO),
        .USER_HI (USER_HI)
    ) u_acv_check (
        .addr     (mar_shadow_r),
        .in_range (in_range_s)
    );

    assign acv_hit_s = (state_r == ACCESS) && PRIV_USER && !in_range_s;
`else
    logic unused_acv_s;
    assign unused_acv_s = PRIV_USER ^ (|USER_LO) ^ (|USER_HI);
    assign acv_hit_s    = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state sequencing; non-memory opcodes skip straight to FIN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    state_nxt_s = is_mem_op(OPCODE) ? ADDR : FIN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR:    state_nxt_s = is_ind_op(opcode_r) ? IND : ACCESS;
            IND:     state_nxt_s = ACCESS;
            ACCESS:  state_nxt_s = FIN;
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Strobes decoded from the state register so reset removes them at once.
    always_comb begin
        MAR_LE      = 1'b0;
        MAR_CONTROL = 1'b0;
        WE          = 1'b0;
        DONE        = 1'b0;
        LOAD_VALID  = 1'b0;
        ACV         = 1'b0;
        BUSY        = (state_r != IDLE);
        case (state_r)
            ADDR: MAR_LE = 1'b1;
            IND: begin
                MAR_LE      = 1'b1;
                MAR_CONTROL = 1'b1;
            end
            ACCESS: WE = is_mem_op(opcode_r) && !is_load_op(opcode_r) && !acv_hit_s;
            FIN: begin
                DONE       = 1'b1;
                LOAD_VALID = is_load_op(opcode_r) && !acv_r;
                ACV        = acv_r;
            end
            default: begin
                MAR_LE = 1'b0;
            end
        endcase
    end

    // Operand capture on accept, load capture in ACCESS, violation flag for FIN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            opcode_r    <= 4'h0;
            y_out_r     <= {ADDR_W{1'b0}};
            wr_data_r   <= {DATA_W{1'b0}};
            load_data_r <= {DATA_W{1'b0}};
            acv_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    acv_r <= 1'b0;
                    if (START) begin
                        opcode_r  <= OPCODE;
                        y_out_r   <= EA;
                        wr_data_r <= SR_DATA;
                    end
                end
                ACCESS: begin
                    acv_r <= acv_hit_s;
                    if (is_load_op(opcode_r) && !acv_hit_s) begin
                        load_data_r <= MEM_DATA;
                    end
                end
                default: begin
                    acv_r <= acv_r;
                end
            endcase
        end
    end

    assign Y_OUT     = y_out_r;
    assign WR_DATA   = wr_data_r;
    assign LOAD_DATA = load_data_r;

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// Self-checking bench for lc3_mem_access_ctrl with a MAR + dataram model and
// an array-based reference of memory contents and the last loaded word.
module tb_lc3_mem_access_ctrl;
    import lc3_pkg::*;

`ifdef LC3_MEM_ACV_EN
    localparam bit ACV_EN = 1'b1;
`else
    localparam bit ACV_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        START = 1'b0;
    logic [3:0]  OPCODE = 4'h0;
    logic [15:0] EA = 16'h0000;
    logic [15:0] SR_DATA = 16'h0000;
    logic        PRIV_USER = 1'b0;
    logic [15:0] MEM_DATA;
    logic [15:0] Y_OUT, WR_DATA, LOAD_DATA;
    logic        MAR_LE, MAR_CONTROL, WE, LOAD_VALID, BUSY, DONE, ACV;

    lc3_mem_access_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OPCODE(OPCODE), .EA(EA),
        .SR_DATA(SR_DATA), .PRIV_USER(PRIV_USER), .MEM_DATA(MEM_DATA),
        .Y_OUT(Y_OUT), .MAR_LE(MAR_LE), .MAR_CONTROL(MAR_CONTROL), .WE(WE),
        .WR_DATA(WR_DATA), .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID),
        .BUSY(BUSY), .DONE(DONE), .ACV(ACV)
    );

    always #5 CLK = ~CLK;

    // Memory stage: MAR register and dataram with combinational read.
    logic [15:0] mar = 16'h0000;
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ref_ld = 16'h0000;
    assign MEM_DATA = mem[mar];

    always @(posedge CLK) begin
        if (MAR_LE) mar <= MAR_CONTROL ? MEM_DATA : Y_OUT;
        if (WE) mem[mar] <= WR_DATA;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outs"}, {MAR_LE, MAR_CONTROL, WE, LOAD_VALID, BUSY, DONE, ACV}, 32'd0);
        chk({tag, "_y"}, Y_OUT, 32'd0);
        chk({tag, "_wr"}, WR_DATA, 32'd0);
        chk({tag, "_ld"}, LOAD_DATA, 32'd0);
    endtask

    function automatic bit op_is_mem(input logic [3:0] op);
        return op == 4'h2 || op == 4'h3 || op == 4'h6 || op == 4'h7 || op == 4'hA || op == 4'hB;
    endfunction

    // One operation: START in an idle cycle, watch strobes until DONE, compare to reference.
    task automatic run_op(input logic [3:0] op, input logic [15:0] ea, input logic [15:0] sr,
                          input logic priv, input bit poke);
        bit          is_mem, is_ld, is_ind, viol;
        logic [15:0] fin_addr, we_addr;
        int          exp_lat, lat, mle_n, mle_first, we_n, we_k;
        logic        lv, av;
        is_mem   = op_is_mem(op);
        is_ld    = (op == 4'h2 || op == 4'h6 || op == 4'hA);
        is_ind   = (op == 4'hA || op == 4'hB);
        fin_addr = is_ind ? ref_mem[ea] : ea;
        viol     = ACV_EN && is_mem && priv && (fin_addr < 16'h3000 || fin_addr > 16'hFDFF);
        exp_lat  = !is_mem ? 1 : (is_ind ? 4 : 3);
        lat = 0; mle_n = 0; mle_first = 0; we_n = 0; we_k = 0; we_addr = 16'h0000;
        lv = 1'b0; av = 1'b0;

        @(negedge CLK);
        chk("idle_busy", {BUSY, DONE}, 32'd0);
        START = 1'b1; OPCODE = op; EA = ea; SR_DATA = sr; PRIV_USER = priv;
        @(posedge CLK);
        #1;
        START = 1'b0; EA = 16'($urandom); SR_DATA = 16'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (poke && k == 1) begin
                START = 1'b1; OPCODE = 4'($urandom);
            end else begin
                START = 1'b0;
            end
            if (MAR_LE) begin
                mle_n++;
                if (mle_first == 0) mle_first = k;
            end
            if (WE) begin
                we_n++; we_k = k; we_addr = mar;
            end
            if (DONE) begin
                lat = k; lv = LOAD_VALID; av = ACV;
                break;
            end
        end
        START = 1'b0;

        if (is_ld && !viol) ref_ld = ref_mem[fin_addr];
        if (is_mem && !is_ld && !viol) ref_mem[fin_addr] = sr;

        chk("latency", lat, exp_lat);
        chk("mar_le_cnt", mle_n, !is_mem ? 0 : (is_ind ? 2 : 1));
        chk("mar_le_first", mle_first, is_mem ? 1 : 0);
        chk("we_cnt", we_n, (is_mem && !is_ld && !viol) ? 1 : 0);
        if (is_mem && !is_ld && !viol) begin
            chk("we_cycle", we_k, exp_lat - 1);
            chk("we_addr", we_addr, fin_addr);
            chk("mem_write", mem[fin_addr], ref_mem[fin_addr]);
        end
        chk("load_valid", lv, is_ld && !viol);
        chk("acv", av, viol);
        chk("load_data", LOAD_DATA, ref_ld);
    endtask

    initial begin
        logic [3:0]  ops [8];
        logic [15:0] old, a;
        ops = '{4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB, 4'h1, 4'h0};
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end

        #2 RST_N = 1'b0;
        #20;
        chk_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // 1: LD from 3050
        mem[16'h3050] = 16'hBEEF; ref_mem[16'h3050] = 16'hBEEF;
        run_op(OP_LD, 16'h3050, 16'h5A5A, 1'b0, 1'b0);
        chk("t1_data", LOAD_DATA, 32'h0000BEEF);

        // 2: STI through pointer at 3100
        mem[16'h3100] = 16'h4000; ref_mem[16'h3100] = 16'h4000;
        run_op(OP_STI, 16'h3100, 16'h1234, 1'b0, 1'b0);
        chk("t2_mem", mem[16'h4000], 32'h00001234);

        // 3: START during BUSY ignored, then non-memory ADD
        run_op(OP_LDR, 16'h3222, 16'h0000, 1'b0, 1'b1);
        run_op(4'h1, 16'h3333, 16'h0000, 1'b0, 1'b0);

        // 4: reset during the ACCESS cycle of an STR
        a = 16'h3456; old = mem[a];
        @(negedge CLK);
        START = 1'b1; OPCODE = OP_STR; EA = a; SR_DATA = ~old;
        @(posedge CLK);
        #1 START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("t4_we_before", WE, 32'd1);
        RST_N = 1'b0;
        #1;
        chk_zero("t4_abort");
        ref_ld = 16'h0000;
        @(posedge CLK);
        #1;
        chk("t4_mem", mem[a], old);
        @(negedge CLK);
        RST_N = 1'b1;

        // 5: user-mode access violation, then the same load in supervisor mode
        if (ACV_EN) begin
            run_op(OP_LD, 16'h3200, 16'h0000, 1'b1, 1'b0);
            run_op(OP_LD, 16'h2FFF, 16'h0000, 1'b1, 1'b0);
            chk("t5_ld_hold", LOAD_DATA, ref_mem[16'h3200]);
            run_op(OP_LD, 16'h2FFF, 16'h0000, 1'b0, 1'b0);
        end

        // 6: back-to-back LDR
        run_op(OP_LDR, 16'h3500, 16'h0000, 1'b0, 1'b0);
        run_op(OP_LDR, 16'h3501, 16'h0000, 1'b0, 1'b0);

        // Random mix, including boundary addresses of the user window
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       a = 16'h2FFF;
                1:       a = 16'hFE00;
                2:       a = 16'h3000;
                default: a = 16'($urandom);
            endcase
            run_op(ops[$urandom_range(0, 7)], a, 16'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
